// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encoding,
// opcode constants and the datapath select encodings it drives.
package multicycle_pkg;

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXEC_R    = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9
   } state_t;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;
   localparam logic [5:0] OP_J   = 6'b000010;

   typedef enum logic [1:0] {
      SRCB_REG    = 2'b00,
      SRCB_FOUR   = 2'b01,
      SRCB_IMM    = 2'b10,
      SRCB_IMM_SH = 2'b11
   } alu_src_b_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10
   } pc_source_t;

   // States that wait on the memory handshake and are covered by the watchdog
   function automatic logic is_mem_wait(input state_t s);
      return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
   endfunction

   // Opcodes this controller knows how to sequence
   function automatic logic is_legal(input logic [5:0] op);
      return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J);
   endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore-style controller for a shared-ALU, shared-memory multi-cycle MIPS
// datapath. Handshakes on mem_ready and aborts stalled accesses via a
// saturating watchdog counter.
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       instr_done,
   output logic       illegal_op,
   output logic       mem_timeout,
   output logic [3:0] state
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT);

   state_t     cur_state;
   state_t     next_state;
   logic [7:0] wait_cnt;
   logic       waiting;
   logic       expired;

   assign waiting = is_mem_wait(cur_state) && !mem_ready;
   assign expired = waiting && (wait_cnt == LIMIT);
   assign state   = cur_state;

   // Next-state selection, including watchdog aborts back to FETCH
   always_comb begin
      next_state = cur_state;
      case (cur_state)
         FETCH: begin
            if (expired)        next_state = FETCH;
            else if (mem_ready) next_state = DECODE;
         end
         DECODE: begin
            case (opcode)
               OP_R:           next_state = EXEC_R;
               OP_LW, OP_SW:   next_state = MEM_ADDR;
               OP_BEQ, OP_BNE: next_state = BRANCH;
               OP_J:           next_state = JUMP;
               default:        next_state = FETCH;
            endcase
         end
         MEM_ADDR:  next_state = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
         MEM_READ: begin
            if (expired)        next_state = FETCH;
            else if (mem_ready) next_state = MEM_WB;
         end
         MEM_WRITE: begin
            if (expired || mem_ready) next_state = FETCH;
         end
         EXEC_R:    next_state = R_WB;
         MEM_WB,
         R_WB,
         BRANCH,
         JUMP:      next_state = FETCH;
         default:   next_state = FETCH;
      endcase
   end

   // State register and watchdog counter; counter clears on any state change or abort
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= FETCH;
         wait_cnt  <= 8'd0;
      end else begin
         cur_state <= next_state;
         if ((next_state != cur_state) || expired || !waiting)
            wait_cnt <= 8'd0;
         else if (wait_cnt != 8'hFF)
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

   // Output decode from state; everything is held low while reset is asserted
   always_comb begin
      pc_en       = 1'b0;
      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_REG;
      alu_op      = ALUOP_ADD;
      pc_source   = PCSRC_ALU;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      mem_timeout = 1'b0;
      if (rst_n) begin
         case (cur_state)
            FETCH: begin
               mem_read    = !expired;
               alu_src_b   = SRCB_FOUR;
               ir_write    = mem_ready;
               pc_en       = mem_ready;
               mem_timeout = expired;
            end
            DECODE: begin
               alu_src_b  = SRCB_IMM_SH;
               illegal_op = !is_legal(opcode);
               instr_done = !is_legal(opcode);
            end
            MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
            end
            MEM_READ: begin
               iord        = 1'b1;
               mem_read    = !expired;
               mem_timeout = expired;
            end
            MEM_WB: begin
               mem_to_reg = 1'b1;
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            MEM_WRITE: begin
               iord        = 1'b1;
               mem_write   = !expired;
               instr_done  = mem_ready;
               mem_timeout = expired;
            end
            EXEC_R: begin
               alu_src_a = 1'b1;
               alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
               reg_dst    = 1'b1;
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            BRANCH: begin
               alu_src_a  = 1'b1;
               alu_op     = ALUOP_SUB;
               pc_source  = PCSRC_ALUOUT;
               pc_en      = alu_zero ^ opcode[0];
               instr_done = 1'b1;
            end
            JUMP: begin
               pc_source  = PCSRC_JUMP;
               pc_en      = 1'b1;
               instr_done = 1'b1;
            end
            default: begin
               pc_en = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into
// an expected per-cycle trace (inputs to drive plus outputs to expect).
module tb_multicycle_control;

   localparam int TO = 4;

   localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_ADDR = 4'd2,
                          S_MRD = 4'd3, S_MWB = 4'd4, S_MWR = 4'd5,
                          S_EXR = 4'd6, S_RWB = 4'd7, S_BR = 4'd8, S_J = 4'd9;

   localparam logic [5:0] C_R = 6'b000000, C_LW = 6'b100011, C_SW = 6'b101011,
                          C_BEQ = 6'b000100, C_BNE = 6'b000101, C_J = 6'b000010;

   localparam logic [17:0] M_PCEN = 18'h20000, M_IORD = 18'h10000,
                           M_MRD = 18'h08000, M_MWR = 18'h04000,
                           M_IRW = 18'h02000, M_RDST = 18'h01000,
                           M_M2R = 18'h00800, M_RW = 18'h00400,
                           M_SRCA = 18'h00200, B_FOUR = 18'h00080,
                           B_IMM = 18'h00100, B_IMMSH = 18'h00180,
                           A_SUB = 18'h00020, A_FUNCT = 18'h00040,
                           P_ALUOUT = 18'h00008, P_JUMP = 18'h00010,
                           M_DONE = 18'h00004, M_ILL = 18'h00002,
                           M_TMO = 18'h00001;

   typedef struct packed {
      logic [5:0]  op;
      logic        ready;
      logic        zero;
      logic [3:0]  st;
      logic [17:0] outs;
   } cyc_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       alu_zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
   logic       mem_to_reg, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic       instr_done, illegal_op, mem_timeout;
   logic [3:0] state;
   logic [17:0] outs_now;

   int   total = 0;
   int   bad = 0;
   int   cycle_no = 0;
   cyc_t trace[$];

   always #5 clk = ~clk;

   multicycle_control #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
      .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
      .instr_done(instr_done), .illegal_op(illegal_op),
      .mem_timeout(mem_timeout), .state(state)
   );

   assign outs_now = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
                      mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, instr_done, illegal_op, mem_timeout};

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic void pushZ(input logic [5:0] op, input logic rdy,
                                 input logic z, input logic [3:0] st,
                                 input logic [17:0] outs);
      cyc_t c;
      c.op = op; c.ready = rdy; c.zero = z; c.st = st; c.outs = outs;
      trace.push_back(c);
   endfunction

   function automatic void push(input logic [5:0] op, input logic rdy,
                                input logic [3:0] st, input logic [17:0] outs);
      pushZ(op, rdy, 1'($urandom), st, outs);
   endfunction

   // Expand one instruction into its expected cycle sequence. fw/mw are the
   // memory wait cycles; a wait of TO or more means the watchdog fires.
   function automatic void buildInstr(input logic [5:0] op, input int fw,
                                      input int mw, input logic z);
      int w;
      logic [17:0] base;
      logic [3:0]  mst;
      logic        taken;
      w = fw;
      if (w >= TO) begin
         for (int i = 0; i < TO; i++) push(op, 1'b0, S_FETCH, M_MRD | B_FOUR);
         push(op, 1'b0, S_FETCH, B_FOUR | M_TMO);
         w = 0;
      end
      for (int i = 0; i < w; i++) push(op, 1'b0, S_FETCH, M_MRD | B_FOUR);
      push(op, 1'b1, S_FETCH, M_MRD | B_FOUR | M_IRW | M_PCEN);
      if (op == C_R) begin
         push(op, 1'($urandom), S_DECODE, B_IMMSH);
         push(op, 1'($urandom), S_EXR, M_SRCA | A_FUNCT);
         push(op, 1'($urandom), S_RWB, M_RDST | M_RW | M_DONE);
      end else if (op == C_LW || op == C_SW) begin
         push(op, 1'($urandom), S_DECODE, B_IMMSH);
         push(op, 1'($urandom), S_ADDR, M_SRCA | B_IMM);
         base = (op == C_LW) ? (M_IORD | M_MRD) : (M_IORD | M_MWR);
         mst  = (op == C_LW) ? S_MRD : S_MWR;
         if (mw >= TO) begin
            for (int i = 0; i < TO; i++) push(op, 1'b0, mst, base);
            push(op, 1'b0, mst, M_IORD | M_TMO);
         end else begin
            for (int i = 0; i < mw; i++) push(op, 1'b0, mst, base);
            if (op == C_LW) begin
               push(op, 1'b1, S_MRD, base);
               push(op, 1'($urandom), S_MWB, M_M2R | M_RW | M_DONE);
            end else begin
               push(op, 1'b1, S_MWR, base | M_DONE);
            end
         end
      end else if (op == C_BEQ || op == C_BNE) begin
         push(op, 1'($urandom), S_DECODE, B_IMMSH);
         taken = (op == C_BEQ) ? z : !z;
         pushZ(op, 1'($urandom), z, S_BR,
               M_SRCA | A_SUB | P_ALUOUT | M_DONE | (taken ? M_PCEN : 18'h0));
      end else if (op == C_J) begin
         push(op, 1'($urandom), S_DECODE, B_IMMSH);
         push(op, 1'($urandom), S_J, P_JUMP | M_PCEN | M_DONE);
      end else begin
         push(op, 1'($urandom), S_DECODE, B_IMMSH | M_ILL | M_DONE);
      end
   endfunction

   // Entered and left just after a rising edge: drive, check mid-cycle, advance
   task automatic applyStimulus(input cyc_t c);
      opcode    = c.op;
      mem_ready = c.ready;
      alu_zero  = c.zero;
      @(negedge clk);
      checkOutput($sformatf("state@%0d op=%b", cycle_no, c.op), 32'(state), 32'(c.st));
      checkOutput($sformatf("outs@%0d op=%b", cycle_no, c.op), 32'(outs_now), 32'(c.outs));
      cycle_no++;
      @(posedge clk);
      #1;
   endtask

   task automatic runTrace();
      while (trace.size() > 0) applyStimulus(trace.pop_front());
   endtask

   initial begin
      logic [5:0] op;
      int         n;
      cyc_t       c;

      #2;
      checkOutput("reset_outs", 32'(outs_now), 32'h0);
      checkOutput("reset_state", 32'(state), 32'(S_FETCH));
      mem_ready = 1'b1;
      #1;
      checkOutput("reset_outs_ready", 32'(outs_now), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      buildInstr(C_R, 0, 0, 1'b0);   runTrace();
      buildInstr(C_LW, 0, 3, 1'b0);  runTrace();
      buildInstr(C_SW, 1, 0, 1'b0);  runTrace();
      buildInstr(C_BNE, 0, 0, 1'b0); runTrace();
      buildInstr(C_BNE, 0, 0, 1'b1); runTrace();
      buildInstr(C_BEQ, 0, 0, 1'b0); runTrace();
      buildInstr(C_BEQ, 0, 0, 1'b1); runTrace();
      buildInstr(C_J, 0, 0, 1'b0);   runTrace();
      buildInstr(6'b001000, 0, 0, 1'b0); runTrace();
      buildInstr(C_R, TO, 0, 1'b0);  runTrace();
      buildInstr(C_LW, 0, TO, 1'b0); runTrace();
      buildInstr(C_SW, 2, TO, 1'b0); runTrace();

      repeat (300) begin
         case ($urandom_range(0, 7))
            0: op = C_R;
            1: op = C_LW;
            2: op = C_SW;
            3: op = C_BEQ;
            4: op = C_BNE;
            5: op = C_J;
            default: op = 6'($urandom);
         endcase
         buildInstr(op,
                    ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, TO - 1)),
                    ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, TO - 1)),
                    1'($urandom));
         runTrace();
      end

      // Asynchronous reset in the middle of a stalled store
      buildInstr(C_SW, 0, 3, 1'b0);
      n = trace.size() - 2;
      for (int i = 0; i < n; i++) applyStimulus(trace.pop_front());
      c = trace.pop_front();
      trace.delete();
      opcode    = c.op;
      mem_ready = 1'b0;
      @(negedge clk);
      checkOutput("pre_reset_mem_write", 32'(mem_write), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_mem_write", 32'(mem_write), 32'h0);
      checkOutput("async_outs", 32'(outs_now), 32'h0);
      checkOutput("async_state", 32'(state), 32'(S_FETCH));
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      buildInstr(C_R, TO, 0, 1'b0);  runTrace();
      buildInstr(C_LW, 0, 1, 1'b0);  runTrace();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore-style FSM that sequences a shared-ALU, shared-memory multi-cycle MIPS datapath for R-type, lw, sw, beq, bne and j. The block sits beside the datapath and reads the opcode from the held instruction register. It drives every mux select and write enable, and resolves the PC write internally from ALU zero. Memory is variable-latency: the block handshakes on mem_ready and uses a watchdog to abort stalled accesses.

Parameters:
TIMEOUT, 255, maximum consecutive cycles spent waiting for mem_ready before the access is aborted (range 1..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], stable from DECODE until the next fetch completes
alu_zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
pc_en  out  1  PC load enable; resolved as PCWrite OR (branch taken)
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load enable
reg_dst  out  1  register-file write address select: 1 = rd, 0 = rt
mem_to_reg  out  1  register-file write data select: 1 = MDR, 0 = ALUOut
reg_write  out  1  register-file write enable
alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register
alu_src_b  out  2  ALU B select: 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
alu_op  out  2  to ALU control: 00 = add, 01 = sub, 10 = decode funct
pc_source  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
mem_timeout  out  1  one-cycle pulse when the watchdog aborts an access
state  out  4  current state, debug only

Behaviour:
- Reset:
  - rst_n low puts state in FETCH and the wait counter at 0.
  - While rst_n is low: pc_en, ir_write, mem_read, mem_write, reg_write and all three pulses are forced to 0; all selects are 0.
- Outputs decode from state, plus mem_ready/alu_zero where noted. Outputs not listed for a state are 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_en=mem_ready.
  - On mem_ready go to DECODE; otherwise stay.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target is captured into ALUOut).
  - Next state by opcode: 000000 -> EXEC_R; 100011/101011 -> MEM_ADDR; 000100/000101 -> BRANCH; 000010 -> JUMP.
  - Any other opcode: illegal_op=1, instr_done=1, go to FETCH.
- MEM_ADDR:
  - alu_src_a=1, alu_src_b=10, alu_op=00.
  - opcode 100011 -> MEM_READ; opcode 101011 -> MEM_WRITE.
- MEM_READ: mem_read=1, iord=1; on mem_ready go to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1; go to FETCH.
- MEM_WRITE: mem_write=1, iord=1; on mem_ready set instr_done=1 and go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; go to R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1; go to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
  - pc_en = alu_zero XOR opcode[0] (beq taken on zero, bne taken on nonzero).
  - instr_done=1; go to FETCH.
- JUMP: pc_source=10, pc_en=1, instr_done=1; go to FETCH.
- Latency in cycles, with memory ready on first request: R-type 4, lw 5, sw 4, beq/bne 3, j 3, illegal 2.
- Watchdog:
  - An 8-bit counter increments each cycle spent in FETCH, MEM_READ or MEM_WRITE with mem_ready=0. It clears on state exit.
  - When the counter equals TIMEOUT with mem_ready still 0: mem_timeout=1, all strobes are 0 that cycle, go to FETCH, counter clears.
  - A timeout in FETCH retries the same PC; PC is not written.
  - The counter saturates and does not wrap.
- mem_ready is ignored in every state other than FETCH, MEM_READ and MEM_WRITE.
- Reset asserted mid-instruction aborts immediately with no partial write; the first cycle after release is FETCH.

Decomposition:
- Package multicycle_pkg holds:
  - state encoding (4-bit enum FETCH=0, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, R_WB, BRANCH, JUMP);
  - opcode constants (R, LW, SW, BEQ, BNE, J);
  - ALUSrcB, ALUOp and PCSource encodings.
- No sub-module. Next-state logic, output decode and the watchdog live in one file.

Test Plan:
- R-type (opcode 000000), mem_ready tied 1 -> FETCH, DECODE, EXEC_R, R_WB; reg_write=1 with reg_dst=1 only in cycle 4; instr_done pulses in cycle 4.
- lw (100011), mem_ready low for 3 cycles in MEM_READ -> 8 cycles total; mem_read/iord held high throughout MEM_READ; reg_write with mem_to_reg=1 exactly once.
- bne (000101) with alu_zero=0 -> pc_en=1 and pc_source=01 in BRANCH. Repeat with alu_zero=1 -> pc_en=0. beq shows the inverse.
- Opcode 001000 -> illegal_op pulse in DECODE, no reg_write/mem_write, back in FETCH at cycle 3.
- TIMEOUT=4, mem_ready held 0 in FETCH -> mem_timeout pulses after 4 waiting cycles, ir_write never asserts, state returns to FETCH.
- rst_n dropped asynchronously during MEM_WRITE -> mem_write falls immediately; after release the state is FETCH and the counter is 0.
